// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in, serial-out transmitter.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit counter: counts accepted bits and flags the last one of the frame.
module bit_counter #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign terminal = (count_reg == CW'(N - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load, per-bit shift
// enable, optional trailing even-parity bit and a one-cycle done pulse.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = clog2(N + 1);

  state_t         state_reg, state_next;
  logic [N-1:0]   shreg_reg;
  logic [N-1:0]   load_word;
  logic [N-1:0]   shifted;
  logic           head;
  logic           load;
  logic           shift;
  logic           cnt_clear;
  logic           cnt_en;
  logic           terminal;

  // Parity sits at the far end of the register so it leaves after the data.
  generate
    if (PARITY_EN != 0) begin : g_par
      if (LSB_FIRST != 0) begin : g_lsb
        assign load_word = {^din, din};
      end else begin : g_msb
        assign load_word = {din, ^din};
      end
    end else begin : g_nopar
      assign load_word = din;
    end

    if (LSB_FIRST != 0) begin : g_shr
      assign head    = shreg_reg[0];
      assign shifted = {1'b0, shreg_reg[N-1:1]};
    end else begin : g_shl
      assign head    = shreg_reg[N-1];
      assign shifted = {shreg_reg[N-2:0], 1'b0};
    end
  endgenerate

  bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        shreg_reg <= load_word;
      end else if (shift) begin
        shreg_reg <= shifted;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load       = 1'b1;
          cnt_clear  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = head;
        if (shift_en) begin
          shift  = 1'b1;
          cnt_en = 1'b1;
          if (terminal) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two instances (LSB-first plain, MSB-first with parity);
// stimulus pushes expected bits/done markers, a negedge monitor pops and compares.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       shift_en;
  logic       lv_a, lr_a, sout_a, sv_a, done_a;
  logic       lv_b, lr_b, sout_b, sv_b, done_b;

  int checks;
  int failures;

  typedef struct packed {
    logic is_done;
    logic val;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (lv_a),
    .load_ready (lr_a),
    .shift_en   (shift_en),
    .sout       (sout_a),
    .sout_valid (sv_a),
    .done       (done_a)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (lv_b),
    .load_ready (lr_b),
    .shift_en   (shift_en),
    .sout       (sout_b),
    .sout_valid (sv_b),
    .done       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // seq is written first-bit-leftmost over n bits.
  task automatic push_seq(input bit which, input logic [15:0] seq, input int n, input bit with_done);
    exp_t it;
    for (int i = n - 1; i >= 0; i--) begin
      it.is_done = 1'b0;
      it.val     = seq[i];
      if (which) exp_b.push_back(it); else exp_a.push_back(it);
    end
    if (with_done) begin
      it.is_done = 1'b1;
      it.val     = 1'b0;
      if (which) exp_b.push_back(it); else exp_a.push_back(it);
    end
  endtask

  task automatic mon_step(input bit which, input logic sv, input logic so, input logic dn);
    exp_t it;
    int   sz;
    string tag;
    tag = which ? "b" : "a";
    sz  = which ? exp_b.size() : exp_a.size();
    if (sv === 1'b1 && shift_en === 1'b1) begin
      if (sz == 0) begin
        check({tag, "_unexpected_bit"}, 32'd1, 32'd0);
      end else begin
        if (which) it = exp_b.pop_front(); else it = exp_a.pop_front();
        check({tag, "_bit_kind"}, {31'd0, it.is_done}, 32'd0);
        check({tag, "_sout"}, {31'd0, so}, {31'd0, it.val});
      end
    end else if (dn === 1'b1) begin
      if (sz == 0) begin
        check({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
        if (which) it = exp_b.pop_front(); else it = exp_a.pop_front();
        check({tag, "_done_kind"}, {31'd0, it.is_done}, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(1'b0, sv_a, sout_a, done_a);
    mon_step(1'b1, sv_b, sout_b, done_b);
  end

  task automatic load_word(input bit which, input logic [7:0] d);
    @(posedge clk); #1;
    din = d;
    if (which) lv_b = 1'b1; else lv_a = 1'b1;
    @(posedge clk); #1;
    lv_a = 1'b0;
    lv_b = 1'b0;
  endtask

  // Counts cycles from the call until done; optional 1,0,0 shift_en pattern.
  task automatic finish_frame(input bit which, input int exp_k, input bit pat, input string name);
    int k;
    k = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) begin
        k = i;
        check({name, "_ready_in_done"}, {31'd0, which ? lr_b : lr_a}, 32'd0);
        break;
      end
      @(posedge clk); #1;
      if (pat) shift_en = (i % 3 == 0);
    end
    check({name, "_done_cycle"}, k, exp_k);
    @(negedge clk);
    check({name, "_ready_after"}, {31'd0, which ? lr_b : lr_a}, 32'd1);
    @(posedge clk); #1;
    shift_en = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    din      = 8'h00;
    lv_a     = 1'b0;
    lv_b     = 1'b0;
    shift_en = 1'b0;

    // 1: asynchronous reset mid-cycle, then idle with no stimulus
    #12 rst = 1'b1;
    #1;
    check("rst_sout", {31'd0, sout_a}, 32'd0);
    check("rst_valid", {31'd0, sv_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_ready", {31'd0, lr_a}, 32'd1);
    check("rst_ready_b", {31'd0, lr_b}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid", {31'd0, sv_a}, 32'd0);
    check("idle_ready", {31'd0, lr_a}, 32'd1);
    check("idle_done", {31'd0, done_a}, 32'd0);
    check("idle_sout", {31'd0, sout_a}, 32'd0);

    // 2: A5 LSB-first
    shift_en = 1'b1;
    push_seq(1'b0, 16'b10100101, 8, 1'b1);
    load_word(1'b0, 8'hA5);
    finish_frame(1'b0, 9, 1'b0, "lsb_a5");

    // 3: 07 MSB-first with parity 1
    push_seq(1'b1, 16'b000001111, 9, 1'b1);
    load_word(1'b1, 8'h07);
    finish_frame(1'b1, 10, 1'b0, "msb_par07");

    // 4: backpressure 1,0,0 on F0; last bit accepted in cycle 22
    push_seq(1'b0, 16'b00001111, 8, 1'b1);
    load_word(1'b0, 8'hF0);
    finish_frame(1'b0, 23, 1'b1, "bp_f0");

    // 5: load_valid with FF during SHIFT of 00 must be ignored
    push_seq(1'b0, 16'b00000000, 8, 1'b1);
    load_word(1'b0, 8'h00);
    din  = 8'hFF;
    lv_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lv_a = 1'b0;
    din  = 8'h00;
    finish_frame(1'b0, 6, 1'b0, "ign_load");

    // 6: reset after the 3rd bit of 3C, then 81
    push_seq(1'b0, 16'b001, 3, 1'b0);
    load_word(1'b0, 8'h3C);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, sv_a}, 32'd0);
    check("abort_ready", {31'd0, lr_a}, 32'd1);
    check("abort_sout", {31'd0, sout_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", {31'd0, done_a}, 32'd0);
    check("abort_queue_a", exp_a.size(), 32'd0);
    push_seq(1'b0, 16'b10000001, 8, 1'b1);
    load_word(1'b0, 8'h81);
    finish_frame(1'b0, 9, 1'b0, "after_abort_81");

    repeat (2) @(negedge clk);
    check("end_queue_a", exp_a.size(), 32'd0);
    check("end_queue_b", exp_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
